// File: rtl/riscv_mem_arbiter_pkg.sv
// Types and constants shared by the instruction/data memory arbiter.
package riscv_mem_arbiter_pkg;

  // Arbiter FSM state; encodings match the ARB_* defines.
  typedef enum logic [1:0] {
    ARB_S_IDLE   = 2'd0,
    ARB_S_BUSY_I = 2'd1,
    ARB_S_BUSY_D = 2'd2
  } arb_state_e;

  // Bit positions of each requester in the req/gnt vectors.
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

endpackage

// File: rtl/riscv_defines.sv
// Shared width and arbiter-state defines for the riscv core slice.
`ifndef RISCV_DEFINES_SV
`define RISCV_DEFINES_SV

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

// Memory arbiter state encodings, visible to top-level benches.
`define ARB_IDLE   2'd0
`define ARB_BUSY_I 2'd1
`define ARB_BUSY_D 2'd2

`endif

// File: rtl/riscv_rr_arb2.sv
// Combinational two-way round-robin pick: imem is bit 0, dmem is bit 1.
module riscv_rr_arb2
  import riscv_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,   // 1 when dmem was served most recently
  output logic [1:0] gnt
);

  // On a tie the requester not served last wins; otherwise the sole requester.
  always_comb begin
    gnt = 2'b00;
    if (req[REQ_I] && req[REQ_D]) begin
      if (last) gnt[REQ_I] = 1'b1;
      else      gnt[REQ_D] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between the core's instruction and data
// ports. Grants round-robin, holds a grant until the memory completes, and
// counts stall cycles caused by contention (saturating).
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = `RISCV_ADDR_WIDTH,
  parameter int DATA_W = `RISCV_WORD_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_valid_i,
  output logic                imem_ready_o,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic [DATA_W-1:0]   imem_rdata_o,
  input  logic                dmem_valid_i,
  output logic                dmem_ready_o,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  input  logic [DATA_W/8-1:0] dmem_we_i,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                stat_clr_i,
  output logic [CNT_W-1:0]    contention_cnt_o
);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic             r_last_d;
  logic             w_last_d_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_i_wait;
  logic             w_d_wait;
  logic             w_cnt_inc;

  assign w_req = {dmem_valid_i, imem_valid_i};

  riscv_rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (r_last_d),
    .gnt  (w_gnt)
  );

  // Next-state and last-served tracking; the owner's own valid is not looked
  // at on completion because it still belongs to the finished request.
  always_comb begin
    w_state_next  = r_state;
    w_last_d_next = r_last_d;
    case (r_state)
      ARB_S_IDLE: begin
        if (w_gnt[REQ_I])      w_state_next = ARB_S_BUSY_I;
        else if (w_gnt[REQ_D]) w_state_next = ARB_S_BUSY_D;
      end
      ARB_S_BUSY_I: begin
        if (mem_ready_i) begin
          w_last_d_next = 1'b0;
          w_state_next  = dmem_valid_i ? ARB_S_BUSY_D : ARB_S_IDLE;
        end
      end
      ARB_S_BUSY_D: begin
        if (mem_ready_i) begin
          w_last_d_next = 1'b1;
          w_state_next  = imem_valid_i ? ARB_S_BUSY_I : ARB_S_IDLE;
        end
      end
      default: w_state_next = ARB_S_IDLE;
    endcase
  end

  // State and last-served register; dmem counts as served last out of reset
  // so imem wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ARB_S_IDLE;
      r_last_d <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_last_d <= w_last_d_next;
    end
  end

  // Memory-side mux and ready forwarding; mem_valid_o decodes only the
  // registered state, so no valid input reaches it combinationally.
  always_comb begin
    mem_valid_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = '0;
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    case (r_state)
      ARB_S_BUSY_I: begin
        mem_valid_o  = 1'b1;
        mem_addr_o   = imem_addr_i;
        imem_ready_o = mem_ready_i;
      end
      ARB_S_BUSY_D: begin
        mem_valid_o  = 1'b1;
        mem_addr_o   = dmem_addr_i;
        mem_wdata_o  = dmem_wdata_i;
        mem_we_o     = dmem_we_i;
        dmem_ready_o = mem_ready_i;
      end
      default: ;
    endcase
  end

  // Read data goes to both requesters; only the one seeing ready uses it.
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

  // A requester is stalled when it is valid, does not own the memory, and is
  // not about to be granted at this edge (from IDLE or by a direct handover).
  always_comb begin
    w_i_wait  = imem_valid_i && (r_state != ARB_S_BUSY_I) && (w_state_next != ARB_S_BUSY_I);
    w_d_wait  = dmem_valid_i && (r_state != ARB_S_BUSY_D) && (w_state_next != ARB_S_BUSY_D);
    w_cnt_inc = w_i_wait || w_d_wait;
  end

  // Saturating contention counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (stat_clr_i) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign contention_cnt_o = r_cnt;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter; a second instance with a 4-bit
// counter shares the stimulus for the saturation scenario.
module tb_riscv_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_valid_i, dmem_valid_i, mem_ready_i, stat_clr_i;
  logic [AW-1:0] imem_addr_i, dmem_addr_i;
  logic [DW-1:0] dmem_wdata_i, mem_rdata_i;
  logic [BW-1:0] dmem_we_i;

  logic          imem_ready_o, dmem_ready_o, mem_valid_o;
  logic [DW-1:0] imem_rdata_o, dmem_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_we_o;
  logic [15:0]   contention_cnt_o;

  logic          c4_imem_ready, c4_dmem_ready, c4_mem_valid;
  logic [DW-1:0] c4_imem_rdata, c4_dmem_rdata, c4_mem_wdata;
  logic [AW-1:0] c4_mem_addr;
  logic [BW-1:0] c4_mem_we;
  logic [3:0]    c4_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o),
    .imem_addr_i(imem_addr_i), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o),
    .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .stat_clr_i(stat_clr_i), .contention_cnt_o(contention_cnt_o)
  );

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .imem_valid_i(imem_valid_i), .imem_ready_o(c4_imem_ready),
    .imem_addr_i(imem_addr_i), .imem_rdata_o(c4_imem_rdata),
    .dmem_valid_i(dmem_valid_i), .dmem_ready_o(c4_dmem_ready),
    .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_we_i(dmem_we_i), .dmem_rdata_o(c4_dmem_rdata),
    .mem_valid_o(c4_mem_valid), .mem_ready_i(mem_ready_i),
    .mem_addr_o(c4_mem_addr), .mem_wdata_o(c4_mem_wdata),
    .mem_we_o(c4_mem_we), .mem_rdata_i(mem_rdata_i),
    .stat_clr_i(stat_clr_i), .contention_cnt_o(c4_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_valid_i = 0; dmem_valid_i = 0; mem_ready_i = 0; stat_clr_i = 0;
    imem_addr_i = '0; dmem_addr_i = '0; dmem_wdata_i = '0; dmem_we_i = '0;
    mem_rdata_i = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid_o); end
    checks++; if ({imem_ready_o, dmem_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {imem_ready_o, dmem_ready_o}); end
    checks++; if (contention_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", contention_cnt_o); end
    checks++; if ({mem_addr_o, mem_wdata_o, mem_we_o} !== '0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h/%h want 0", mem_addr_o, mem_wdata_o, mem_we_o); end
    $display("reset: mem_valid=%b cnt=%0d", mem_valid_o, contention_cnt_o);
  endtask

  task automatic test_imem_single();
    imem_valid_i = 1; imem_addr_i = 32'h10; mem_ready_i = 1; mem_rdata_i = 32'h1234_5678;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", mem_valid_o); end
    step();
    checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL single_mem_valid: got %b want 1", mem_valid_o); end
    checks++; if (mem_addr_o !== 32'h10) begin errors++; $display("FAIL single_addr: got %h want 00000010", mem_addr_o); end
    checks++; if (imem_ready_o !== 1'b1 || dmem_ready_o !== 1'b0) begin errors++; $display("FAIL single_ready: got i=%b d=%b want i=1 d=0", imem_ready_o, dmem_ready_o); end
    checks++; if (imem_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL single_rdata: got %h want 12345678", imem_rdata_o); end
    checks++; if (mem_we_o !== 4'h0 || mem_wdata_o !== 32'h0) begin errors++; $display("FAIL single_we: got we=%h wdata=%h want 0/0", mem_we_o, mem_wdata_o); end
    step();
    imem_valid_i = 0;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL single_back_idle: got %b want 0", mem_valid_o); end
    checks++; if (contention_cnt_o !== 16'd0) begin errors++; $display("FAIL single_cnt: got %0d want 0", contention_cnt_o); end
    $display("imem single: addr=10 rdata=%h cnt=%0d", imem_rdata_o, contention_cnt_o);
  endtask

  task automatic test_tie_from_reset();
    apply_reset();
    imem_valid_i = 1; imem_addr_i = 32'h20;
    dmem_valid_i = 1; dmem_addr_i = 32'h40; dmem_wdata_i = 32'hDEAD_BEEF; dmem_we_i = 4'hF;
    mem_ready_i = 1; mem_rdata_i = 32'h0;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL tie_idle_valid: got %b want 0", mem_valid_o); end
    step();
    checks++; if (imem_ready_o !== 1'b1 || dmem_ready_o !== 1'b0) begin errors++; $display("FAIL tie_first_imem: got i=%b d=%b want i=1 d=0", imem_ready_o, dmem_ready_o); end
    checks++; if (mem_addr_o !== 32'h20 || mem_we_o !== 4'h0) begin errors++; $display("FAIL tie_first_bus: got addr=%h we=%h want 20/0", mem_addr_o, mem_we_o); end
    step();
    imem_valid_i = 0;
    #1;
    checks++; if (mem_valid_o !== 1'b1 || dmem_ready_o !== 1'b1) begin errors++; $display("FAIL tie_second_dmem: got valid=%b dready=%b want 1/1", mem_valid_o, dmem_ready_o); end
    checks++; if (mem_addr_o !== 32'h40 || mem_we_o !== 4'hF || mem_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tie_write_bus: got addr=%h we=%h wdata=%h want 40/F/DEADBEEF", mem_addr_o, mem_we_o, mem_wdata_o); end
    step();
    dmem_valid_i = 0; dmem_we_i = 0; dmem_wdata_i = 0;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL tie_end_idle: got %b want 0", mem_valid_o); end
    checks++; if (contention_cnt_o !== 16'd1) begin errors++; $display("FAIL tie_cnt: got %0d want 1", contention_cnt_o); end
    $display("tie: order I then D, cnt=%0d", contention_cnt_o);
  endtask

  task automatic test_back_to_back();
    stat_clr_i = 1;
    step();
    stat_clr_i = 0;
    imem_valid_i = 1; imem_addr_i = 32'h100;
    dmem_valid_i = 1; dmem_addr_i = 32'h200; mem_ready_i = 1;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %b want 0", mem_valid_o); end
    step();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d: got %b want 1", k, mem_valid_o); end
      checks++; if (imem_ready_o !== (k % 2 == 0) || dmem_ready_o !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_order k=%0d: got i=%b d=%b want i=%b", k, imem_ready_o, dmem_ready_o, (k % 2 == 0)); end
      checks++; if (mem_addr_o !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin errors++; $display("FAIL b2b_addr k=%0d: got %h", k, mem_addr_o); end
      $display("b2b k=%0d: i_ready=%b d_ready=%b addr=%h", k, imem_ready_o, dmem_ready_o, mem_addr_o);
      if (k == 6) imem_valid_i = 0;
      if (k == 7) dmem_valid_i = 0;
      step();
    end
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end_idle: got %b want 0", mem_valid_o); end
    checks++; if (contention_cnt_o !== 16'd1) begin errors++; $display("FAIL b2b_cnt: got %0d want 1", contention_cnt_o); end
  endtask

  task automatic test_wait_states();
    int pulses;
    pulses = 0;
    imem_valid_i = 1; imem_addr_i = 32'h30; mem_ready_i = 1;
    step();
    step();
    imem_valid_i = 0; mem_ready_i = 0; stat_clr_i = 1;
    step();
    stat_clr_i = 0;
    imem_valid_i = 1; imem_addr_i = 32'h30;
    dmem_valid_i = 1; dmem_addr_i = 32'h80; dmem_we_i = 0; dmem_wdata_i = 0;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL wait_idle_valid: got %b want 0", mem_valid_o); end
    step();
    for (int k = 0; k < 4; k++) begin
      mem_ready_i = (k == 3); mem_rdata_i = 32'hCAFE_F00D;
      #1;
      checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h80 || mem_we_o !== 4'h0) begin errors++; $display("FAIL wait_hold k=%0d: got valid=%b addr=%h we=%h want 1/80/0", k, mem_valid_o, mem_addr_o, mem_we_o); end
      checks++; if (dmem_ready_o !== (k == 3) || imem_ready_o !== 1'b0) begin errors++; $display("FAIL wait_ready k=%0d: got d=%b i=%b", k, dmem_ready_o, imem_ready_o); end
      if (dmem_ready_o === 1'b1) begin
        pulses++;
        checks++; if (dmem_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL wait_rdata: got %h want CAFEF00D", dmem_rdata_o); end
      end
      step();
    end
    dmem_valid_i = 0; mem_ready_i = 1;
    #1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL wait_pulses: got %0d want 1", pulses); end
    checks++; if (mem_addr_o !== 32'h30 || imem_ready_o !== 1'b1) begin errors++; $display("FAIL wait_handover: got addr=%h iready=%b want 30/1", mem_addr_o, imem_ready_o); end
    checks++; if (contention_cnt_o !== 16'd4) begin errors++; $display("FAIL wait_cnt: got %0d want 4", contention_cnt_o); end
    $display("wait states: dmem pulses=%0d cnt=%0d", pulses, contention_cnt_o);
    step();
    imem_valid_i = 0; mem_ready_i = 0;
    #1;
  endtask

  task automatic test_reset_mid();
    dmem_valid_i = 1; dmem_addr_i = 32'h44; mem_ready_i = 0;
    step();
    checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", mem_valid_o); end
    step();
    rst_n = 0;
    step();
    rst_n = 1; dmem_valid_i = 0; mem_ready_i = 1;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", mem_valid_o); end
    checks++; if ({imem_ready_o, dmem_ready_o} !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b want 00", {imem_ready_o, dmem_ready_o}); end
    step();
    checks++; if (mem_valid_o !== 1'b0 || dmem_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got valid=%b dready=%b want 0/0", mem_valid_o, dmem_ready_o); end
    mem_ready_i = 0;
    $display("reset mid-transaction: mem_valid=%b", mem_valid_o);
  endtask

  task automatic test_saturation();
    stat_clr_i = 1;
    step();
    stat_clr_i = 0; dmem_valid_i = 1; dmem_addr_i = 32'h50; mem_ready_i = 0;
    step();
    imem_valid_i = 1; imem_addr_i = 32'h60;
    for (int k = 0; k < 20; k++) step();
    checks++; if (c4_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", c4_cnt); end
    checks++; if (contention_cnt_o !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d want 20", contention_cnt_o); end
    mem_ready_i = 1;
    step();
    dmem_valid_i = 0;
    step();
    imem_valid_i = 0; mem_ready_i = 0;
    #1;
    checks++; if (c4_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold4: got %0d want 15", c4_cnt); end
    stat_clr_i = 1;
    step();
    stat_clr_i = 0;
    checks++; if (c4_cnt !== 4'd0 || contention_cnt_o !== 16'd0) begin errors++; $display("FAIL sat_clear: got %0d/%0d want 0/0", c4_cnt, contention_cnt_o); end
    $display("saturation: cnt4 cleared to %0d", c4_cnt);
  endtask

  initial begin
    test_reset();
    test_imem_single();
    test_tie_from_reset();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
